// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage, plus the RISC-V constants it reuses.
package riscv;
  localparam logic [31:0] I_NOP = 32'h0000_0013;
endpackage

package fetch_stage_pkg;
  typedef enum logic {RUN, FLUSH} fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port (req/gnt, in-order rvalid).
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage_fifo.sv
// Small power-of-two FIFO with clear; head is visible combinationally.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  T                       wdata_i,
  output T                       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign do_push = push_i & ~clear_i;
  assign do_pop  = pop_i & ~clear_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(do_push && full_o && !do_pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(do_pop && empty_o));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: sequential PC generation, bounded in-flight requests,
// response buffering and redirect flush feeding the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic                 ifid_valid_o,
  output logic [31:0]          ifid_instr_o,
  output logic [31:0]          ifid_pc_o
);
  localparam int              CW      = $clog2(IBUF_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(IBUF_DEPTH);
  localparam ifid_bus_t       BUBBLE  = '{valid: 1'b0, pc: 32'h0, instr: riscv::I_NOP};

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;
  ifid_bus_t     ifid_q, ifid_d;

  logic [CW-1:0] outst, ibuf_cnt, outst_nxt;
  logic [31:0]   rsp_pc;
  fetch_entry_t  ibuf_head;
  logic          ibuf_full, ibuf_empty, pcq_full, pcq_empty;
  logic          req, fire, accept, bypass, push, pop;

  // Outstanding count is the occupancy of the PC FIFO that shadows in-flight requests.
  assign req       = ~rst & (state_q == RUN) & ((outst + ibuf_cnt) < DEPTH_C);
  assign fire      = req & imem.gnt;
  assign accept    = imem.rvalid & (discard_q == '0) & ~redirect_i;
  assign bypass    = accept & ibuf_empty & ~stall_i;
  assign push      = accept & ~bypass;
  assign pop       = ~redirect_i & ~stall_i & ~ibuf_empty;
  assign outst_nxt = outst + CW'(fire) - CW'(imem.rvalid);

  fetch_fifo #(.DEPTH(IBUF_DEPTH), .T(logic [31:0])) u_pcq (
    .clk, .rst,
    .push_i(fire), .pop_i(imem.rvalid), .clear_i(1'b0),
    .wdata_i(pc_q), .rdata_o(rsp_pc),
    .count_o(outst), .full_o(pcq_full), .empty_o(pcq_empty)
  );

  fetch_fifo #(.DEPTH(IBUF_DEPTH), .T(fetch_entry_t)) u_ibuf (
    .clk, .rst,
    .push_i(push), .pop_i(pop), .clear_i(redirect_i),
    .wdata_i('{pc: rsp_pc, instr: imem.rdata}), .rdata_o(ibuf_head),
    .count_o(ibuf_cnt), .full_o(ibuf_full), .empty_o(ibuf_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      discard_q <= '0;
      ifid_q    <= BUBBLE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      ifid_q    <= ifid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    ifid_d    = ifid_q;
    if (fire) pc_d = pc_q + 32'd4;
    if (imem.rvalid && discard_q != '0) discard_d = discard_q - CW'(1);
    if (redirect_i) begin
      // Everything still in flight after this edge belongs to the old path.
      pc_d      = word_align(redirect_pc_i);
      discard_d = outst_nxt;
      ifid_d    = BUBBLE;
      state_d   = (outst_nxt != '0) ? FLUSH : RUN;
    end else begin
      if (!stall_i) begin
        if (!ibuf_empty)  ifid_d = '{valid: 1'b1, pc: ibuf_head.pc, instr: ibuf_head.instr};
        else if (bypass)  ifid_d = '{valid: 1'b1, pc: rsp_pc, instr: imem.rdata};
        else              ifid_d = BUBBLE;
      end
      if (state_q == FLUSH && discard_d == '0) state_d = RUN;
    end
  end

  assign imem.req     = req;
  assign imem.addr    = pc_q;
  assign ifid_valid_o = ifid_q.valid;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_pc_o    = ifid_q.pc;

  a_pcq_ovf:    assert property (@(posedge clk) disable iff (rst) !(fire && pcq_full));
  a_rsp_orphan: assert property (@(posedge clk) disable iff (rst) imem.rvalid |-> !pcq_empty);
  a_ibuf_ovf:   assert property (@(posedge clk) disable iff (rst) !(push && ibuf_full && !pop));
  a_discard:    assert property (@(posedge clk) disable iff (rst) discard_q <= outst);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, redirect flush, grant
// back-pressure, PC wrap and mid-stream reset.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, resp_en;
  logic [31:0] rpc;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc;
  int          total = 0;
  int          bad   = 0;

  fetch_stage_if imem();

  fetch_stage #(.RESET_PC(RST_PC), .IBUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(rpc), .imem(imem),
    .ifid_valid_o(ifid_valid), .ifid_instr_o(ifid_instr), .ifid_pc_o(ifid_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] P(input int k);
    return RST_PC + 32'(4 * k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'(v));
    chk({tag, ".pc"}, ifid_pc, v ? pc : 32'h0);
    chk({tag, ".instr"}, ifid_instr, v ? rd(pc) : NOP);
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, 32'(imem.req), 32'(r));
    if (r) chk({tag, ".addr"}, imem.addr, a);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // Memory model: grants sampled just before the edge, returned in order
  // from the cycle after the grant while resp_en is high.
  initial begin
    logic [31:0] q[$];
    logic        f;
    logic [31:0] a;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    forever begin
      @(negedge clk); #4;
      f = imem.req & imem.gnt;
      a = imem.addr;
      @(posedge clk); #1;
      if (rst) begin
        q.delete();
        imem.rvalid = 1'b0;
      end else begin
        if (f) q.push_back(a);
        if (resp_en && q.size() != 0) begin
          imem.rvalid = 1'b1;
          imem.rdata  = rd(q.pop_front());
        end else begin
          imem.rvalid = 1'b0;
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = '0; resp_en = 1'b1;
    imem.gnt = 1'b1;
    repeat (2) nx();
    chk_req("rst", 1'b0, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0);

    // Streaming from RESET_PC, one word per cycle, wrapping past 0xFFFF_FFFC.
    rst = 1'b0; #1;
    chk_req("n0", 1'b1, P(0));
    nx(); chk_ifid("n1", 1'b0, 0);    chk_req("n1", 1'b1, P(1));
    nx(); chk_ifid("n2", 1'b1, P(0)); chk_req("n2_wrap", 1'b1, 32'h0);
    nx(); chk_ifid("n3", 1'b1, P(1));
    nx(); chk_ifid("n4", 1'b1, P(2)); stall = 1'b1;

    // Stall three cycles: outputs frozen, requests stop at two in flight.
    for (int i = 0; i < 3; i++) begin
      nx(); chk_ifid("stall", 1'b1, 32'h0); chk_req("stall", 1'b0, 0);
    end
    stall = 1'b0;
    nx(); chk_ifid("n8", 1'b1, P(3)); chk_req("n8", 1'b1, P(5));
    nx(); chk_ifid("n9", 1'b1, P(4));
    nx(); chk_ifid("n10", 1'b1, P(5)); resp_en = 1'b0;

    // Build two outstanding requests, then redirect (low bits ignored).
    nx(); chk_ifid("n11", 1'b1, P(6)); chk_req("n11", 1'b1, P(8));
    nx(); chk_ifid("n12", 1'b0, 0); chk_req("n12", 1'b0, 0);
    redirect = 1'b1; rpc = 32'h0000_0103; resp_en = 1'b1;
    nx(); redirect = 1'b0;
    chk_ifid("flush1", 1'b0, 0); chk_req("flush1", 1'b0, 0);
    nx(); chk_ifid("flush2", 1'b0, 0); chk_req("flush2", 1'b0, 0);
    nx(); chk_ifid("n15", 1'b0, 0); chk_req("n15", 1'b1, 32'h100);
    nx(); chk_ifid("n16", 1'b0, 0);
    nx(); chk_ifid("n17", 1'b1, 32'h100);

    // Redirect together with stall: redirect wins.
    stall = 1'b1; redirect = 1'b1; rpc = 32'h0000_0200;
    nx(); chk_ifid("rd_stall", 1'b0, 0); chk_req("rd_stall", 1'b0, 0);
    redirect = 1'b0; stall = 1'b0;
    nx(); chk_ifid("n19", 1'b0, 0); chk_req("n19", 1'b1, 32'h200);
    nx(); chk_ifid("n20", 1'b0, 0);
    nx(); chk_ifid("n21", 1'b1, 32'h200); chk_req("n21", 1'b1, 32'h208);

    // Grant withheld four cycles: address held.
    imem.gnt = 1'b0;
    nx(); chk_ifid("n22", 1'b1, 32'h204); chk_req("nognt", 1'b1, 32'h208);
    for (int i = 0; i < 3; i++) begin
      nx(); chk_req("nognt", 1'b1, 32'h208);
    end
    imem.gnt = 1'b1;
    nx(); chk_req("n26", 1'b1, 32'h20C);
    nx(); chk_ifid("n27", 1'b1, 32'h208);

    // Asynchronous reset mid-stream, then restart at RESET_PC.
    rst = 1'b1; #1;
    chk_req("arst", 1'b0, 0);
    chk_ifid("arst", 1'b0, 0);
    nx(); rst = 1'b0; #1;
    chk_req("restart", 1'b1, P(0));
    nx(); chk_ifid("r1", 1'b0, 0);
    nx(); chk_ifid("r2", 1'b1, P(0));
    nx(); chk_ifid("r3", 1'b1, P(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
